// File: rtl/iiitb_elc_req_sched.sv
// SCAN-ordered request scheduler feeding the elevator controller: latches floor
// requests, issues one one-hot target at a time, retires it on complete.
module iiitb_elc_req_sched #(
  parameter int unsigned NFLOORS = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NFLOORS-1:0] button,
  input  logic [NFLOORS-1:0] current_floor,
  input  logic               complete,
  input  logic               door_alert,
  input  logic               weight_alert,
  output logic [NFLOORS-1:0] request_floor,
  output logic               req_valid,
  output logic [NFLOORS-1:0] pending,
  output logic               sched_dir,
  output logic               busy,
  output logic               pos_err
);

  localparam int unsigned IDXW = (NFLOORS > 1) ? $clog2(NFLOORS) : 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SELECT = 2'd1,
    ST_ISSUED = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [NFLOORS-1:0]  pending_q, pending_d;
  logic [NFLOORS-1:0]  req_floor_q, req_floor_d;
  logic                req_valid_q, req_valid_d;
  logic                dir_q, dir_d;
  logic                busy_q;
  logic                pos_err_q, pos_err_d;
  logic [NFLOORS-1:0]  clear_mask;

  logic [IDXW-1:0]     cur_idx;
  logic [IDXW-1:0]     lo_above_idx, hi_below_idx;
  logic                lo_above_vld, hi_below_vld;

  // Nearest pending floor on either side of the current position
  always_comb begin
    cur_idx      = '0;
    lo_above_idx = '0;
    lo_above_vld = 1'b0;
    hi_below_idx = '0;
    hi_below_vld = 1'b0;
    for (int i = 0; i < NFLOORS; i++) begin
      if (current_floor[i]) cur_idx = IDXW'(i);
    end
    for (int i = NFLOORS - 1; i >= 0; i--) begin
      if (pending_q[i] && (IDXW'(i) > cur_idx)) begin
        lo_above_vld = 1'b1;
        lo_above_idx = IDXW'(i);
      end
    end
    for (int i = 0; i < NFLOORS; i++) begin
      if (pending_q[i] && (IDXW'(i) < cur_idx)) begin
        hi_below_vld = 1'b1;
        hi_below_idx = IDXW'(i);
      end
    end
  end

  // Next-state, target selection and retire
  always_comb begin
    state_d     = state_q;
    req_floor_d = req_floor_q;
    req_valid_d = req_valid_q;
    dir_d       = dir_q;
    pos_err_d   = 1'b0;
    clear_mask  = '0;
    unique case (state_q)
      ST_IDLE: begin
        if ((|pending_q) && !door_alert && !weight_alert) state_d = ST_SELECT;
      end
      ST_SELECT: begin
        state_d = ST_ISSUED;
        if (!$onehot(current_floor)) begin
          pos_err_d = 1'b1;
          state_d   = ST_IDLE;
        end else if (|(pending_q & current_floor)) begin
          req_floor_d = current_floor;
        end else if (dir_q ? lo_above_vld : hi_below_vld) begin
          req_floor_d = NFLOORS'(1) << (dir_q ? lo_above_idx : hi_below_idx);
        end else if (dir_q ? hi_below_vld : lo_above_vld) begin
          req_floor_d = NFLOORS'(1) << (dir_q ? hi_below_idx : lo_above_idx);
          dir_d       = ~dir_q;
        end else begin
          state_d = ST_IDLE;
        end
        req_valid_d = (state_d == ST_ISSUED);
      end
      ST_ISSUED: begin
        if (complete && (current_floor == req_floor_q)) begin
          clear_mask  = req_floor_q;
          req_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // A same-cycle press of the retiring floor re-latches it
    pending_d = (pending_q & ~clear_mask) | button;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      pending_q   <= '0;
      req_floor_q <= '0;
      req_valid_q <= 1'b0;
      dir_q       <= 1'b1;
      busy_q      <= 1'b0;
      pos_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      req_floor_q <= req_floor_d;
      req_valid_q <= req_valid_d;
      dir_q       <= dir_d;
      busy_q      <= (state_d != ST_IDLE);
      pos_err_q   <= pos_err_d;
    end
  end

  assign request_floor = req_floor_q;
  assign req_valid     = req_valid_q;
  assign pending       = pending_q;
  assign sched_dir     = dir_q;
  assign busy          = busy_q;
  assign pos_err       = pos_err_q;

endmodule

// File: tb/tb_iiitb_elc_req_sched.sv
// Directed bench for the SCAN request scheduler; status vector is
// {pending, request_floor, req_valid, sched_dir, busy, pos_err}.
module tb_iiitb_elc_req_sched;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] button, current_floor, request_floor, pending;
  logic       complete, door_alert, weight_alert;
  logic       req_valid, sched_dir, busy, pos_err;

  int n_checks = 0;
  int n_fail   = 0;

  iiitb_elc_req_sched #(.NFLOORS(8)) dut (
    .clk           (clk),
    .reset         (reset),
    .button        (button),
    .current_floor (current_floor),
    .complete      (complete),
    .door_alert    (door_alert),
    .weight_alert  (weight_alert),
    .request_floor (request_floor),
    .req_valid     (req_valid),
    .pending       (pending),
    .sched_dir     (sched_dir),
    .busy          (busy),
    .pos_err       (pos_err)
  );

  always #5 clk = ~clk;

  function automatic logic [19:0] status();
    return {pending, request_floor, req_valid, sched_dir, busy, pos_err};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [19:0] st;
    reset = 1'b1; button = 8'hFF; current_floor = 8'h01;
    complete = 1'b0; door_alert = 1'b0; weight_alert = 1'b0;
    step();
    reset = 1'b0; button = 8'h00;
    st = status();
    n_checks++;
    if (st !== {8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL reset_state: got %h want %h", st, {8'h00, 8'h00, 4'b0100});
    end
  endtask

  task automatic test_basic();
    logic [19:0] st;
    current_floor = 8'h01; button = 8'h10;
    step();
    button = 8'h00;
    st = status(); n_checks++;
    if (st !== {8'h10, 8'h00, 4'b0100}) begin
      n_fail++; $display("FAIL basic_latch: got %h want %h", st, {8'h10, 8'h00, 4'b0100});
    end
    step();
    st = status(); n_checks++;
    if (st !== {8'h10, 8'h00, 4'b0110}) begin
      n_fail++; $display("FAIL basic_select: got %h want %h", st, {8'h10, 8'h00, 4'b0110});
    end
    step();
    st = status(); n_checks++;
    if (st !== {8'h10, 8'h10, 4'b1110}) begin
      n_fail++; $display("FAIL basic_issue: got %h want %h", st, {8'h10, 8'h10, 4'b1110});
    end
    current_floor = 8'h10; complete = 1'b1;
    step();
    complete = 1'b0;
    st = status(); n_checks++;
    if (st !== {8'h00, 8'h10, 4'b0100}) begin
      n_fail++; $display("FAIL basic_retire: got %h want %h", st, {8'h00, 8'h10, 4'b0100});
    end
  endtask

  task automatic test_scan();
    logic [19:0] st;
    current_floor = 8'h08; button = 8'h42;
    step();
    button = 8'h00;
    step(); step();
    st = status(); n_checks++;
    if (st !== {8'h42, 8'h40, 4'b1110}) begin
      n_fail++; $display("FAIL scan_first_up: got %h want %h", st, {8'h42, 8'h40, 4'b1110});
    end
    current_floor = 8'h40; complete = 1'b1;
    step();
    complete = 1'b0;
    step(); step();
    st = status(); n_checks++;
    if (st !== {8'h02, 8'h02, 4'b1010}) begin
      n_fail++; $display("FAIL scan_reverse_down: got %h want %h", st, {8'h02, 8'h02, 4'b1010});
    end
    current_floor = 8'h02; complete = 1'b1;
    step();
    complete = 1'b0;
  endtask

  task automatic test_alert();
    logic [19:0] st;
    weight_alert = 1'b1; button = 8'h04;
    step();
    button = 8'h00;
    step(); step(); step();
    st = status(); n_checks++;
    if (st !== {8'h04, 8'h02, 4'b0000}) begin
      n_fail++; $display("FAIL alert_hold: got %h want %h", st, {8'h04, 8'h02, 4'b0000});
    end
    weight_alert = 1'b0;
    step(); step();
    st = status(); n_checks++;
    if (st !== {8'h04, 8'h04, 4'b1110}) begin
      n_fail++; $display("FAIL alert_release_issue: got %h want %h", st, {8'h04, 8'h04, 4'b1110});
    end
    current_floor = 8'h04; complete = 1'b1;
    step();
    complete = 1'b0;
  endtask

  task automatic test_mismatch_set_wins();
    logic [19:0] st;
    button = 8'h20;
    step();
    button = 8'h00;
    step(); step();
    door_alert = 1'b1; current_floor = 8'h08; complete = 1'b1;
    step();
    complete = 1'b0;
    st = status(); n_checks++;
    if (st !== {8'h20, 8'h20, 4'b1110}) begin
      n_fail++; $display("FAIL mismatch_ignored: got %h want %h", st, {8'h20, 8'h20, 4'b1110});
    end
    door_alert = 1'b0; current_floor = 8'h20; complete = 1'b1; button = 8'h20;
    step();
    complete = 1'b0; button = 8'h00;
    st = status(); n_checks++;
    if (st !== {8'h20, 8'h20, 4'b0100}) begin
      n_fail++; $display("FAIL set_wins_retire: got %h want %h", st, {8'h20, 8'h20, 4'b0100});
    end
    step(); step();
    st = status(); n_checks++;
    if (st !== {8'h20, 8'h20, 4'b1110}) begin
      n_fail++; $display("FAIL set_wins_reissue: got %h want %h", st, {8'h20, 8'h20, 4'b1110});
    end
    complete = 1'b1;
    step();
    complete = 1'b0;
    st = status(); n_checks++;
    if (st !== {8'h00, 8'h20, 4'b0100}) begin
      n_fail++; $display("FAIL reissue_retire: got %h want %h", st, {8'h00, 8'h20, 4'b0100});
    end
  endtask

  task automatic test_reset_mid();
    logic [19:0] st;
    button = 8'h81;
    step();
    button = 8'h00;
    step(); step();
    st = status(); n_checks++;
    if (st !== {8'h81, 8'h80, 4'b1110}) begin
      n_fail++; $display("FAIL mid_issue: got %h want %h", st, {8'h81, 8'h80, 4'b1110});
    end
    reset = 1'b1; button = 8'h04;
    step();
    reset = 1'b0; button = 8'h00;
    st = status(); n_checks++;
    if (st !== {8'h00, 8'h00, 4'b0100}) begin
      n_fail++; $display("FAIL mid_reset: got %h want %h", st, {8'h00, 8'h00, 4'b0100});
    end
  endtask

  task automatic test_pos_err();
    logic [19:0] st;
    current_floor = 8'h08; button = 8'h01;
    step();
    button = 8'h00;
    step();
    current_floor = 8'h03;
    step();
    st = status(); n_checks++;
    if (st !== {8'h01, 8'h00, 4'b0101}) begin
      n_fail++; $display("FAIL pos_err_pulse: got %h want %h", st, {8'h01, 8'h00, 4'b0101});
    end
    current_floor = 8'h01;
    step();
    st = status(); n_checks++;
    if (st !== {8'h01, 8'h00, 4'b0110}) begin
      n_fail++; $display("FAIL pos_err_clear: got %h want %h", st, {8'h01, 8'h00, 4'b0110});
    end
    step();
    st = status(); n_checks++;
    if (st !== {8'h01, 8'h01, 4'b1110}) begin
      n_fail++; $display("FAIL pos_err_recover: got %h want %h", st, {8'h01, 8'h01, 4'b1110});
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_scan();
    test_alert();
    test_mismatch_set_wins();
    test_reset_mid();
    test_pos_err();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/iiitb_elc_req_sched.md
# iiitb_elc_req_sched

Request scheduler that sits directly upstream of the elevator controller. It latches cabin and hall button presses for 8 floors into a pending set and picks one target floor at a time using SCAN (elevator) ordering. It drives the controller's one-hot `request_floor`, and it retires each request when the controller reports `complete` at that floor. The controller's `out_current_floor` and alert outputs feed back into this block.

## Interface

Parameters:
- `NFLOORS`, default 8: number of floors; sets the width of every floor vector.

Ports:
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `reset`, in, 1: synchronous, active-high.
- `button`, in, NFLOORS: OR of cabin and hall buttons. Multi-hot allowed. Each bit is sampled every cycle.
- `current_floor`, in, NFLOORS: one-hot floor position, taken from the controller's `out_current_floor`.
- `complete`, in, 1: controller has arrived at `request_floor`.
- `door_alert`, in, 1: controller door alert; blocks new selection while high.
- `weight_alert`, in, 1: controller weight alert; blocks new selection while high.
- `request_floor`, out, NFLOORS: one-hot target floor sent to the controller.
- `req_valid`, out, 1: `request_floor` is an active, unserved target.
- `pending`, out, NFLOORS: set of latched, unserved requests.
- `sched_dir`, out, 1: sweep direction; 1 = up (toward the MSB), 0 = down.
- `busy`, out, 1: high when the FSM is not in IDLE.
- `pos_err`, out, 1: `current_floor` was not one-hot during SELECT.

## Operation

- Pending register is updated every cycle as `pending_next = (pending & ~clear_mask) | button`.
  - `clear_mask` is the target's one-hot bit in the retire cycle, and 0 otherwise.
  - A press of the target floor in the retire cycle re-latches that floor (set wins).
- FSM states are IDLE, SELECT and ISSUED.
- IDLE:
  - Go to SELECT when `pending != 0` and both alerts are low.
  - Otherwise stay in IDLE.
- SELECT (lasts exactly one cycle):
  - `current_floor` must be one-hot. If it is not, set `pos_err` for one cycle and return to IDLE with no issue.
  - Priority 1: a pending bit at the current floor is the target.
  - Priority 2, when `sched_dir` = 1: the lowest pending floor strictly above the current floor. If there is none, take the highest pending floor below and set `sched_dir` to 0.
  - Priority 2, when `sched_dir` = 0: the mirror of the up case (highest pending floor strictly below; else lowest pending floor above and set `sched_dir` to 1).
  - After selection, go to ISSUED.
- ISSUED:
  - Hold `request_floor` and keep `req_valid` = 1.
  - Retire when `complete` = 1 and `current_floor == request_floor`: clear the pending bit, drop `req_valid`, and go to IDLE.
  - `complete` at any other floor is ignored.
  - Alerts do not cancel an ISSUED request.
- `request_floor` keeps its last value after retire. Only `req_valid` qualifies it.
- `busy` = (state != IDLE).

## Timing

- Reset values: `pending` = 0, `request_floor` = 0, `req_valid` = 0, `sched_dir` = 1, `busy` = 0, `pos_err` = 0, state = IDLE.
- Reset takes effect at the next rising edge and overrides every other input, including a `button` press in the same cycle. Reset in ISSUED abandons the request.
- Issue latency:
  - A button high before edge k sets `pending` at edge k.
  - IDLE moves to SELECT at edge k+1.
  - `request_floor` and `req_valid` are valid from edge k+2.
- Retire:
  - `complete` is sampled high at edge m.
  - At edge m, `req_valid` falls to 0 and the pending bit clears.
  - The earliest next issue is at edge m+2 (IDLE, then SELECT, then ISSUED).
- `sched_dir` changes only on the SELECT-to-ISSUED edge.
- An alert rising in the same cycle that IDLE would leave blocks the transition.
- `pos_err` is a single-cycle pulse, high only during the cycle after a failed SELECT.
- Pending bits are never lost while in SELECT or ISSUED; only the retire cycle clears a bit.

## Test plan

- Reset, then `current_floor` = 8'h01 and a one-cycle `button` = 8'h10 → `pending` = 8'h10 after 1 edge; `request_floor` = 8'h10 with `req_valid` = 1 two edges later. Then `complete` with `current_floor` = 8'h10 → `req_valid` = 0 and `pending` = 8'h00.
- SCAN order: `current_floor` = 8'h08, `sched_dir` = 1, pending = 8'h42 → first target 8'h40 (`sched_dir` stays 1). After retire at 8'h40, next target 8'h02 and `sched_dir` = 0.
- Alert hold: `weight_alert` = 1 with pending = 8'h04 → FSM stays in IDLE and `req_valid` = 0. Alert drops → `request_floor` = 8'h04 two edges later.
- Mismatched complete: target 8'h20, `complete` pulsed while `current_floor` = 8'h08 → no change. Pulse again at 8'h20 → retire.
- Set-wins rule: during the retire cycle for 8'h20, `button` = 8'h20 → `pending` = 8'h20 afterwards and the floor is reissued.
- Reset mid-operation while ISSUED with pending = 8'h81 → the next edge gives all outputs at their reset values. Separately, `current_floor` = 8'h03 in SELECT → `pos_err` pulses and no issue occurs.
